// File: rtl/xalu_muldiv_pkg.sv
// Shared definitions for the XALU multiply/divide unit: op encodings,
// default latencies and op classification helpers.
package xalu_muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MSUB  = 4'd5,
    OP_MTHI  = 4'd6,
    OP_MTLO  = 4'd7,
    OP_MFHI  = 4'd8,
    OP_MFLO  = 4'd9
  } xalu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_multicycle(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/xalu_calc.sv
// Combinational HI/LO result generator: all multiply, accumulate, divide
// and move-to arithmetic. valid=0 means HI/LO must not be written.
module xalu_calc
  import xalu_muldiv_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] new_hi,
  output logic [31:0] new_lo,
  output logic        valid
);

  logic signed [63:0] rs_s64, rt_s64, sprod;
  logic        [63:0] uprod, acc;
  logic signed [31:0] sdvd, sdvs, squot, srem;
  logic        [31:0] udvs, uquot, urem;
  logic               dvs_zero, div_ovf;

  assign rs_s64 = $signed({{32{rs_val[31]}}, rs_val});
  assign rt_s64 = $signed({{32{rt_val[31]}}, rt_val});
  assign sprod  = rs_s64 * rt_s64;
  assign uprod  = {32'd0, rs_val} * {32'd0, rt_val};
  assign acc    = {hi, lo};

  // A divisor of 1 stands in for zero and for the INT_MIN/-1 overflow case;
  // the latter yields exactly the required quotient 0x80000000, remainder 0.
  assign dvs_zero = (rt_val == 32'd0);
  assign div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
  assign sdvd     = $signed(rs_val);
  assign sdvs     = (dvs_zero || div_ovf) ? 32'sd1 : $signed(rt_val);
  assign squot    = sdvd / sdvs;
  assign srem     = sdvd % sdvs;
  assign udvs     = dvs_zero ? 32'd1 : rt_val;
  assign uquot    = rs_val / udvs;
  assign urem     = rs_val % udvs;

  always_comb begin
    new_hi = hi;
    new_lo = lo;
    valid  = 1'b0;
    case (op)
      OP_MULT:  begin {new_hi, new_lo} = $unsigned(sprod);       valid = 1'b1; end
      OP_MULTU: begin {new_hi, new_lo} = uprod;                  valid = 1'b1; end
      OP_MADD:  begin {new_hi, new_lo} = acc + $unsigned(sprod); valid = 1'b1; end
      OP_MSUB:  begin {new_hi, new_lo} = acc - $unsigned(sprod); valid = 1'b1; end
      OP_DIV: begin
        if (!dvs_zero) begin
          new_lo = $unsigned(squot);
          new_hi = $unsigned(srem);
          valid  = 1'b1;
        end
      end
      OP_DIVU: begin
        if (!dvs_zero) begin
          new_lo = uquot;
          new_hi = urem;
          valid  = 1'b1;
        end
      end
      OP_MTHI: begin new_hi = rs_val; valid = 1'b1; end
      OP_MTLO: begin new_lo = rs_val; valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/xalu_muldiv.sv
// EX-stage multiply/divide unit: owns HI/LO, models multi-cycle latency with
// a busy counter and raises stall_req to hold XALU instructions in decode.
module xalu_muldiv
  import xalu_muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [CNT_W-1:0] counter;
  logic [0:0]       state;
  logic [31:0]      calc_hi, calc_lo, pend_hi, pend_lo;
  logic             calc_valid, pend_valid;
  logic             accept, accept_multi;

  xalu_calc u_calc (
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi),
    .lo     (lo),
    .new_hi (calc_hi),
    .new_lo (calc_lo),
    .valid  (calc_valid)
  );

  assign state        = (counter != '0) ? S_RUN : S_IDLE;
  assign busy         = (state == S_RUN);
  assign stall_req    = busy | (start & is_multicycle(op));
  assign rd_data      = (op == OP_MFHI) ? hi : lo;
  assign accept       = start && (state == S_IDLE);
  assign accept_multi = accept && is_multicycle(op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter    <= '0;
      hi         <= '0;
      lo         <= '0;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_multi) begin
            counter    <= is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_valid <= calc_valid;
          end else if (accept && calc_valid) begin
            hi <= calc_hi;
            lo <= calc_lo;
          end
        end
        default: begin
          // Result retires on the last busy edge so it is visible as busy falls.
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1) && pend_valid) begin
            hi <= calc_hi_hold(pend_hi);
            lo <= pend_lo;
          end
        end
      endcase
    end
  end

  // Pending result is pure data; reset discards it by clearing the counter.
  always_ff @(posedge clk) begin
    if (accept_multi) begin
      pend_hi <= calc_hi;
      pend_lo <= calc_lo;
    end
  end

  function automatic logic [31:0] calc_hi_hold(input logic [31:0] v);
    return v;
  endfunction

endmodule

// File: tb/tb_xalu_muldiv.sv
// Self-checking bench for xalu_muldiv: directed scenarios plus random ops
// against a plain-arithmetic HI/LO reference model.
module tb_xalu_muldiv;
  import xalu_muldiv_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy, stall_req;
  logic [31:0] hi, lo, rd_data;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;

  xalu_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // Reference model: architectural effect of one accepted op on HI/LO.
  task automatic model_step(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int cyc);
    longint      sa, sb, q, r;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {ref_hi, ref_lo};
    cyc = 0;
    case (o)
      OP_MULT:  begin {ref_hi, ref_lo} = sa * sb; cyc = MC; end
      OP_MULTU: begin {ref_hi, ref_lo} = {32'd0, a} * {32'd0, b}; cyc = MC; end
      OP_MADD:  begin {ref_hi, ref_lo} = acc + 64'(sa * sb); cyc = MC; end
      OP_MSUB:  begin {ref_hi, ref_lo} = acc - 64'(sa * sb); cyc = MC; end
      OP_DIV: begin
        cyc = DC;
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa - q * sb;
          ref_lo = q[31:0];
          ref_hi = r[31:0];
        end
      end
      OP_DIVU: begin
        cyc = DC;
        if (b != 32'd0) begin
          ref_lo = a / b;
          ref_hi = a - (a / b) * b;
        end
      end
      OP_MTHI: ref_hi = a;
      OP_MTLO: ref_lo = a;
      default: ;
    endcase
  endtask

  // Issues one op from idle and measures how many sampled cycles busy stays high.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc_obs, output int cyc_exp, output logic stall_obs,
                        output logic [31:0] rd_obs, output logic [31:0] rd_exp);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    stall_obs = stall_req;
    rd_obs    = rd_data;
    rd_exp    = (o == OP_MFHI) ? ref_hi : ref_lo;
    model_step(o, a, b, cyc_exp);
    @(posedge clk); #1;
    start = 1'b0;
    cyc_obs = 0;
    @(negedge clk);
    while (busy !== 1'b0 && cyc_obs < 100) begin
      cyc_obs++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int c, ce; logic s; logic [31:0] rd, rde;
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, c, ce, s, rd, rde);
    n_cmp++; if (c !== 5) begin n_err++; $display("FAIL mult_cycles: got %0d want 5", c); end
    n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL mult_stall: got %b want 1", s); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, c, ce, s, rd, rde);
    n_cmp++; if (hi !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi: got %h want 00000001", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_div();
    int c, ce; logic s; logic [31:0] rd, rde;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, c, ce, s, rd, rde);
    n_cmp++; if (c !== 10) begin n_err++; $display("FAIL div_cycles: got %0d want 10", c); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    run_op(OP_DIVU, 32'd7, 32'd2, c, ce, s, rd, rde);
    n_cmp++; if (lo !== 32'd3) begin n_err++; $display("FAIL divu_lo: got %h want 3", lo); end
    n_cmp++; if (hi !== 32'd1) begin n_err++; $display("FAIL divu_hi: got %h want 1", hi); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c, ce, s, rd, rde);
    n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
  endtask

  task automatic test_div_zero();
    int c, ce; logic s; logic [31:0] rd, rde;
    run_op(OP_MTHI, 32'h1234_5678, 32'd0, c, ce, s, rd, rde);
    n_cmp++; if (c !== 0) begin n_err++; $display("FAIL mthi_cycles: got %0d want 0", c); end
    n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL mthi_stall: got %b want 0", s); end
    run_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0, c, ce, s, rd, rde);
    run_op(OP_DIV, 32'd5, 32'd0, c, ce, s, rd, rde);
    n_cmp++; if (c !== 10) begin n_err++; $display("FAIL divz_cycles: got %0d want 10", c); end
    n_cmp++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL divz_hi: got %h want 12345678", hi); end
    n_cmp++; if (lo !== 32'h9ABC_DEF0) begin n_err++; $display("FAIL divz_lo: got %h want 9abcdef0", lo); end
  endtask

  task automatic test_accumulate();
    int c, ce; logic s; logic [31:0] rd, rde;
    run_op(OP_MTHI, 32'd0, 32'd0, c, ce, s, rd, rde);
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, c, ce, s, rd, rde);
    run_op(OP_MADD, 32'd1, 32'd1, c, ce, s, rd, rde);
    n_cmp++; if (c !== 5) begin n_err++; $display("FAIL madd_cycles: got %0d want 5", c); end
    n_cmp++; if (hi !== 32'd1) begin n_err++; $display("FAIL madd_hi: got %h want 1", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL madd_lo: got %h want 0", lo); end
    run_op(OP_MSUB, 32'd2, 32'd3, c, ce, s, rd, rde);
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL msub_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL msub_lo: got %h want fffffffa", lo); end
    run_op(OP_MFHI, 32'd0, 32'd0, c, ce, s, rd, rde);
    n_cmp++; if (rd !== 32'd0) begin n_err++; $display("FAIL mfhi_rd: got %h want 0", rd); end
    run_op(OP_MFLO, 32'd0, 32'd0, c, ce, s, rd, rde);
    n_cmp++; if (rd !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mflo_rd: got %h want fffffffa", rd); end
    n_cmp++; if (c !== 0) begin n_err++; $display("FAIL mflo_cycles: got %0d want 0", c); end
  endtask

  task automatic test_busy_ignore();
    int ce;
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4;
    model_step(OP_MULT, 32'd3, 32'd4, ce);
    @(posedge clk); #1;
    for (int i = 0; i < MC; i++) begin
      if (i % 2 == 0) begin op = OP_MTLO; rs_val = 32'h0000_DEAD; rt_val = 32'd0; end
      else begin op = OP_MULT; rs_val = 32'd5; rt_val = 32'd6; end
      @(negedge clk);
      n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL ign_stall[%0d]: got %b want 1", i, stall_req); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy[%0d]: got %b want 1", i, busy); end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_done_busy: got %b want 0", busy); end
    n_cmp++; if (lo !== 32'd12) begin n_err++; $display("FAIL ign_lo: got %h want 0000000c", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL ign_hi: got %h want 0", hi); end
  endtask

  task automatic test_async_reset();
    int c, ce; logic s; logic [31:0] rd, rde;
    run_op(OP_MTHI, 32'h0000_AAAA, 32'd0, c, ce, s, rd, rde);
    run_op(OP_MTLO, 32'h0000_5555, 32'd0, c, ce, s, rd, rde);
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL areset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL areset_lo: got %h want 0", lo); end
    #1;
    reset = 1'b0;
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
        n_err++; $display("FAIL areset_stale[%0d]: got hi=%h lo=%h busy=%b want 0/0/0", i, hi, lo, busy);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int c, ce, r; logic s; logic [31:0] rd, rde, a, b; logic [3:0] o;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 12);
      o = (r == 12) ? 4'd15 : 4'(r);
      a = pick_operand();
      b = pick_operand();
      run_op(o, a, b, c, ce, s, rd, rde);
      n_cmp++; if (c !== ce) begin n_err++; $display("FAIL rnd_cycles[%0d] op=%0d: got %0d want %0d", i, o, c, ce); end
      n_cmp++; if (s !== (ce != 0)) begin n_err++; $display("FAIL rnd_stall[%0d] op=%0d: got %b want %b", i, o, s, ce != 0); end
      n_cmp++; if (rd !== rde) begin n_err++; $display("FAIL rnd_rd[%0d] op=%0d: got %h want %h", i, o, rd, rde); end
      n_cmp++;
      if (hi !== ref_hi || lo !== ref_lo) begin
        n_err++; $display("FAIL rnd_hilo[%0d] op=%0d a=%h b=%h: got %h_%h want %h_%h", i, o, a, b, hi, lo, ref_hi, ref_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_accumulate();
    test_busy_ignore();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xalu_muldiv.md
Name: xalu_muldiv

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline; executes every instruction the decode stage flags with usingXALU.
- Ops: mult, multu, div, divu, madd, msub, mthi, mtlo, mfhi, mflo.
- Owns the architectural HI/LO registers and models multi-cycle latency with a busy counter.
- Exposes a stall request that the hazard controller uses to hold XALU instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/msub.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  EX-stage XALU instruction valid this cycle.
- op  in  4  operation code, from the shared package encoding.
- rs_val  in  32  forwarded GPR[rs] value.
- rt_val  in  32  forwarded GPR[rt] value.
- busy  out  1  multi-cycle operation in progress.
- stall_req  out  1  combinational: busy | (start & op is a multi-cycle op).
- hi  out  32  HI register.
- lo  out  32  LO register.
- rd_data  out  32  combinational: hi when op==MFHI, else lo.

Behaviour:
- Reset (async, any time, including mid-operation): hi=0, lo=0, busy=0, counter=0, pending result discarded. stall_req and rd_data follow their combinational equations.
- States: IDLE (counter==0), RUN (counter!=0). busy = (counter!=0).
- Multi-cycle op in IDLE, start=1, sampled at edge t:
  - Result is computed from rs_val/rt_val and latched into a pending {hi,lo} pair.
  - counter loads N (MULT_CYCLES or DIV_CYCLES).
  - busy is high for cycles t+1..t+N.
  - At edge t+N (counter==1), hi/lo take the pending values and counter goes to 0.
  - New hi/lo are visible in the same cycle busy falls.
- mthi/mtlo with start=1 in IDLE: hi (or lo) = rs_val at the next edge; no busy.
- mfhi/mflo: no state change; rd_data is valid in the same cycle.
- start=1 while busy: ignored, with no state change, for any op. The hazard controller must stall.
- Arithmetic:
  - mult: signed 32x32 to 64 bits, {hi,lo}=product.
  - multu: unsigned product.
  - madd: {hi,lo} += signed product, 64-bit, wraps modulo 2^64.
  - msub: {hi,lo} -= signed product, wraps.
  - The madd/msub accumulator operand is the {hi,lo} value at the start edge.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (div or divu): hi/lo keep their prior values at completion; busy still runs DIV_CYCLES.
- Unknown op with start=1: no effect.

Decomposition:
- Shared package: XALU op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MSUB=5, MTHI=6, MTLO=7, MFHI=8, MFLO=9); default cycle-count constants; an is_multicycle(op) helper.
- One combinational sub-module, xalu_calc: (op, rs_val, rt_val, hi, lo) -> {new_hi, new_lo, valid}. It contains all arithmetic and the divide-by-zero rule.
- The top level holds the counter/FSM, the pending register and HI/LO.

Test Plan:
- mult 0xFFFFFFFF,2 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div -7,2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7,2 -> lo=3, hi=1. div 0x80000000,0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0x12345678 then mtlo 0x9ABCDEF0, then div 5,0 -> busy 10 cycles, and afterwards hi=0x12345678, lo=0x9ABCDEF0 unchanged.
- Accumulate:
  - hi=0, lo=0xFFFFFFFF; madd 1,1 -> hi=1, lo=0.
  - Then msub 2,3 -> hi=0, lo=0xFFFFFFFA.
  - mfhi -> rd_data=0; mflo -> rd_data=0xFFFFFFFA, same cycle.
- During busy from mult 3,4:
  - start with mtlo 0xDEAD is ignored.
  - start with mult 5,6 is ignored.
  - stall_req=1 throughout.
  - Final lo=12, hi=0.
- Assert reset asynchronously (between clock edges) in the 4th busy cycle of a div -> busy=0, hi=0, lo=0 immediately. After release, no stale write occurs 6 cycles later.
